// File: rtl/axi_test_ctrl.sv
// axi_test_ctrl: AXI4-Lite test-control slave exposing TOHOST, SCRATCH and a cycle counter
// in a 16-byte window at base_addr. Optional feature macro: AXI_TEST_CTRL_CYCLE_EN
// (defined: 64-bit cycle counter with HI shadow; undefined: CYCLE_LO/CYCLE_HI read 0).
module axi_test_ctrl #(
    parameter logic [31:0] base_addr = 32'h0000_4000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [31:0] M_AXI_ARADDR,
    input  logic [2:0]  M_AXI_ARSIZE,
    input  logic        M_AXI_ARVALID,
    output logic        M_AXI_ARREADY,
    output logic [31:0] M_AXI_RDATA,
    output logic [1:0]  M_AXI_RRESP,
    output logic        M_AXI_RVALID,
    input  logic        M_AXI_RREADY,
    input  logic [31:0] M_AXI_AWADDR,
    input  logic [2:0]  M_AXI_AWSIZE,
    input  logic        M_AXI_AWVALID,
    output logic        M_AXI_AWREADY,
    input  logic [31:0] M_AXI_WDATA,
    input  logic [3:0]  M_AXI_WSTRB,
    input  logic        M_AXI_WVALID,
    output logic        M_AXI_WREADY,
    output logic [1:0]  M_AXI_BRESP,
    output logic        M_AXI_BVALID,
    input  logic        M_AXI_BREADY,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] fail_code
);
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [2:0] MAX_SIZE    = 3'd2;

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;

    r_state_e        r_state_q, r_state_d;
    w_state_e        w_state_q, w_state_d;
    logic            arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [31:2]     awaddr_q, awaddr_d;
    logic [2:0]      awsize_q, awsize_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   tohost_q, tohost_d, scratch_q, scratch_d;
    logic            done_q, done_d, pass_q, pass_d;
    logic            ar_hs_c, rd_lo_c;
    logic [1:0]      rd_resp_c;
    logic [DW-1:0]   rd_data_c, cycle_lo_c, cycle_hi_c;
    logic            unused_addr_c;

    assign unused_addr_c = ^{M_AXI_ARADDR[1:0], M_AXI_AWADDR[1:0]};
    assign ar_hs_c       = M_AXI_ARVALID && arready_q;

`ifdef AXI_TEST_CTRL_CYCLE_EN
    logic [63:0]   cycle_q;
    logic [DW-1:0] shadow_q;

    // Free-running cycle counter; CYCLE_LO reads snapshot the upper word into the shadow.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cycle_q  <= '0;
            shadow_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (ar_hs_c && rd_lo_c) shadow_q <= cycle_q[63:32];
        end
    end

    assign cycle_lo_c = cycle_q[31:0];
    assign cycle_hi_c = shadow_q;
`else
    logic unused_cycle_c;
    assign unused_cycle_c = rd_lo_c;
    assign cycle_lo_c     = '0;
    assign cycle_hi_c     = '0;
`endif

    // Read decode of the current AR request against pre-write register values.
    always_comb begin
        rd_resp_c = RESP_OKAY;
        rd_data_c = '0;
        rd_lo_c   = 1'b0;
        if (M_AXI_ARADDR[31:4] != base_addr[31:4]) begin
            rd_resp_c = RESP_DECERR;
        end else if (M_AXI_ARSIZE > MAX_SIZE) begin
            rd_resp_c = RESP_SLVERR;
        end else begin
            case (M_AXI_ARADDR[3:2])
                2'd0:    rd_data_c = tohost_q;
                2'd1:    begin rd_data_c = cycle_lo_c; rd_lo_c = 1'b1; end
                2'd2:    rd_data_c = cycle_hi_c;
                default: rd_data_c = scratch_q;
            endcase
        end
    end

    // Read channel next-state and registered outputs.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (ar_hs_c) begin
                r_state_d = R_RESP;
                rvalid_d  = 1'b1;
                rdata_d   = rd_data_c;
                rresp_d   = rd_resp_c;
            end
            R_RESP: if (rvalid_q && M_AXI_RREADY) begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // Write channel capture, register update and response generation.
    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        tohost_d  = tohost_q;
        scratch_d = scratch_q;
        done_d    = done_q;
        pass_d    = pass_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_got_q && w_got_q) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_OKAY;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    if (awaddr_q[31:4] != base_addr[31:4]) begin
                        bresp_d = RESP_DECERR;
                    end else if (awsize_q > MAX_SIZE) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        case (awaddr_q[3:2])
                            2'd0: begin
                                if (wstrb_q != 4'hF) begin
                                    bresp_d = RESP_SLVERR;
                                end else if ((wdata_q != '0) && !done_q) begin
                                    tohost_d = wdata_q;
                                    done_d   = 1'b1;
                                    pass_d   = (wdata_q == 32'd1);
                                end
                            end
                            2'd1, 2'd2: bresp_d = RESP_SLVERR;
                            default: begin
                                for (int i = 0; i < int'(SW); i++) begin
                                    if (wstrb_q[i]) scratch_d[8*i +: 8] = wdata_q[8*i +: 8];
                                end
                            end
                        endcase
                    end
                end else begin
                    if (M_AXI_AWVALID && awready_q) begin
                        aw_got_d = 1'b1;
                        awaddr_d = M_AXI_AWADDR[31:2];
                        awsize_d = M_AXI_AWSIZE;
                    end
                    if (M_AXI_WVALID && wready_q) begin
                        w_got_d = 1'b1;
                        wdata_d = M_AXI_WDATA;
                        wstrb_d = M_AXI_WSTRB;
                    end
                end
            end
            W_RESP: if (bvalid_q && M_AXI_BREADY) begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            tohost_q  <= '0;
            scratch_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            tohost_q  <= tohost_d;
            scratch_q <= scratch_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign M_AXI_ARREADY = arready_q;
    assign M_AXI_RVALID  = rvalid_q;
    assign M_AXI_RDATA   = rdata_q;
    assign M_AXI_RRESP   = rresp_q;
    assign M_AXI_AWREADY = awready_q;
    assign M_AXI_WREADY  = wready_q;
    assign M_AXI_BVALID  = bvalid_q;
    assign M_AXI_BRESP   = bresp_q;
    assign test_done     = done_q;
    assign test_pass     = pass_q;
    assign fail_code     = tohost_q[31:1];

endmodule

// File: doc/axi_test_ctrl.md
AXI_TEST_CTRL -- requirements
Module: axi_test_ctrl

Interface
REQ-001 Parameter base_addr, default 32'h0000_4000, is the base of the 16-byte register window.
REQ-002 ACLK  input  1  single clock; all logic on rising edge.
REQ-003 ARESETn  input  1  asynchronous active-low reset.
REQ-004 M_AXI_ARADDR/ARSIZE/ARVALID  input  32/3/1; M_AXI_ARREADY  output  1: read address channel.
REQ-005 M_AXI_RDATA/RRESP/RVALID  output  32/2/1; M_AXI_RREADY  input  1: read data channel.
REQ-006 M_AXI_AWADDR/AWSIZE/AWVALID  input  32/3/1; M_AXI_AWREADY  output  1: write address channel.
REQ-007 M_AXI_WDATA/WSTRB/WVALID  input  32/4/1; M_AXI_WREADY  output  1: write data channel.
REQ-008 M_AXI_BRESP/BVALID  output  2/1; M_AXI_BREADY  input  1: write response channel.
REQ-009 test_done  output  1 sticky finish; test_pass  output  1 pass flag; fail_code  output  31 TOHOST[31:1].

Function
REQ-010 Map (offset = addr[3:2]): 0 TOHOST RW; 1 CYCLE_LO RO; 2 CYCLE_HI RO; 3 SCRATCH RW.
REQ-011 addr[31:4] != base_addr[31:4] -> RESP 2'b11 (DECERR), read data 0, no state change.
REQ-012 ARSIZE/AWSIZE > 3'd2 -> RESP 2'b10 (SLVERR), no state change.
REQ-013 Read FSM R_IDLE -> R_RESP on ARVALID&&ARREADY; ARREADY=1 only in R_IDLE.
REQ-014 RVALID asserted cycle after AR handshake; RDATA/RRESP sampled at handshake edge, stable until RREADY.
REQ-015 R_RESP -> R_IDLE on RVALID&&RREADY; next AR accepted no earlier than following cycle.
REQ-016 Write FSM W_IDLE: AWREADY high until AW captured, WREADY high until W captured, independently, either order.
REQ-017 Both captured (same or different cycles) -> write performed on next edge, BVALID asserted same edge, state W_RESP.
REQ-018 W_RESP -> W_IDLE on BVALID&&BREADY; AWREADY/WREADY low throughout W_RESP.
REQ-019 SCRATCH write honours WSTRB per byte lane; WSTRB=0 -> OKAY, no change.
REQ-020 TOHOST write requires WSTRB=4'hF else SLVERR, no change.
REQ-021 TOHOST write of 0 ignored (OKAY); nonzero while test_done=0 -> TOHOST=WDATA, test_done=1, test_pass=(WDATA==1), fail_code=WDATA[31:1].
REQ-022 TOHOST write while test_done=1 -> OKAY, ignored; done/pass/fail_code sticky until reset.
REQ-023 Writes to CYCLE_LO/CYCLE_HI -> SLVERR, no effect.
REQ-024 64-bit cycle counter increments every cycle after reset release, wraps 2^64-1 -> 0.
REQ-025 Read of CYCLE_LO returns counter[31:0] and loads counter[63:32] into HI shadow in same cycle; CYCLE_HI reads return shadow.
REQ-026 Simultaneous read and write of same register: read returns pre-write value.
REQ-027 RRESP/BRESP 2'b00 (OKAY) unless REQ-011/012/020/023 apply.

Reset
REQ-028 ARESETn low -> FSMs idle, all outputs 0, TOHOST/SCRATCH/shadow/counter 0, immediately (asynchronous).
REQ-029 READY outputs registered; first high on first ACLK edge after ARESETn rises.
REQ-030 Reset mid-transaction abandons it; no response issued after reset release.

Configuration
REQ-031 Macro AXI_TEST_CTRL_CYCLE_EN defined: counter and HI shadow per REQ-024/025.
REQ-032 Macro undefined: no counter; CYCLE_LO/CYCLE_HI read 0 with OKAY; writes still SLVERR.

Verification
REQ-033 Write TOHOST 32'h1 at 0x4000, WSTRB F -> BRESP 00, test_done=1, test_pass=1, fail_code=0.
REQ-034 Write TOHOST 32'h7, then 32'h1 -> test_pass=0, fail_code=3, second write OKAY and ignored.
REQ-035 W 2 cycles before AW to SCRATCH, WDATA 32'hA5A5_A5A5 WSTRB 4'h3 over 32'h1111_1111 -> read 32'h1111_A5A5, BVALID cycle after AW.
REQ-036 Read CYCLE_LO, then CYCLE_HI, with RREADY held low 5 cycles -> RDATA stable while RVALID; HI equals upper word at LO read; LO increases across back-to-back reads.
REQ-037 Read 0x5000 -> RRESP 11, RDATA 0; AWSIZE 3'd3 write to SCRATCH -> BRESP 10, SCRATCH unchanged.
REQ-038 ARESETn low during W_RESP with BREADY=0 -> BVALID drops immediately, no B after release, SCRATCH reads 0.
